// File: rtl/button_conditioner_if.sv
// Push-button bundle between the raw switch inputs / mode state machine and
// the button conditioner.
//   *_raw   : raw asynchronous active-high buttons
//   adjust  : 1 while the state machine is in an adjust mode
//   up..center : one-cycle press / auto-repeat pulses
//   held    : debounced levels {up,down,left,right,center}
// master = button/state-machine side, slave = conditioner side.
interface button_conditioner_if;
  logic       up_raw;
  logic       down_raw;
  logic       left_raw;
  logic       right_raw;
  logic       center_raw;
  logic       adjust;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       center;
  logic [4:0] held;

  modport master (
    output up_raw, down_raw, left_raw, right_raw, center_raw, adjust,
    input  up, down, left, right, center, held
  );

  modport slave (
    input  up_raw, down_raw, left_raw, right_raw, center_raw, adjust,
    output up, down, left, right, center, held
  );
endinterface

// File: rtl/button_conditioner.sv
// Five-button front end: per button a 2-FF synchronizer, a debounce filter
// and a rising-edge one-shot; up/down additionally auto-repeat while held in
// adjust mode.
// Ports:
//   clk : system clock, all state on posedge
//   rst : asynchronous active-low reset
//   bus : button_conditioner_if.slave (raw buttons + adjust in,
//         pulses + debounced levels out)
// Bit order of internal 5-bit vectors matches held: {up,down,left,right,center}.
module button_conditioner #(
  parameter int DEB_CYCLES   = 20000,
  parameter int REPEAT_DELAY = 50000,
  parameter int REPEAT_RATE  = 10000
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  localparam int DW   = $clog2(DEB_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] REP_DELAY_C = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RATE_C  = RW'(REPEAT_RATE);

  logic [4:0]    w_raw;
  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [4:0]    r_stable;
  logic [4:0]    r_stable_d;
  logic [4:0]    r_pulse;
  logic [4:0]    w_press;
  logic [4:0]    w_fire;
  logic [DW-1:0] r_deb_cnt [5];

  // Repeat logic: index 1 = up, index 0 = down.
  logic [RW-1:0] r_hold_cnt [2];
  logic [1:0]    r_armed;
  logic [1:0]    w_run;
  logic [1:0]    w_hit;
  logic          w_both;

  assign w_raw = {bus.up_raw, bus.down_raw, bus.left_raw, bus.right_raw, bus.center_raw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A new level is accepted after it has differed from stable for DEB_CYCLES
  // consecutive samples; any return to the stable level restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable <= '0;
      for (int unsigned i = 0; i < 5; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_stable[i]  <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  // Hold timer starts counting on the first cycle the debounced level is seen
  // high, so the first repeat lands REPEAT_DELAY cycles after the press pulse.
  // After a repeat the counter restarts at 1 because that cycle already counts.
  always_comb begin
    w_both = r_stable[4] & r_stable[3];
    w_run  = '0;
    w_hit  = '0;
    for (int unsigned j = 0; j < 2; j++) begin
      w_run[j] = r_stable[3 + j] & bus.adjust & ~w_both;
      w_hit[j] = w_run[j] &&
                 (r_hold_cnt[j] == (r_armed[j] ? REP_RATE_C : REP_DELAY_C));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed <= '0;
      for (int unsigned j = 0; j < 2; j++) r_hold_cnt[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < 2; j++) begin
        if (!w_run[j]) begin
          r_hold_cnt[j] <= '0;
          r_armed[j]    <= 1'b0;
        end else if (w_hit[j]) begin
          r_hold_cnt[j] <= RW'(1);
          r_armed[j]    <= 1'b1;
        end else begin
          r_hold_cnt[j] <= r_hold_cnt[j] + RW'(1);
        end
      end
    end
  end

  assign w_fire = {w_hit[1], w_hit[0], 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable_d <= '0;
      r_pulse    <= '0;
    end else begin
      r_stable_d <= r_stable;
      r_pulse    <= w_press | w_fire;
    end
  end

  assign bus.up     = r_pulse[4];
  assign bus.down   = r_pulse[3];
  assign bus.left   = r_pulse[2];
  assign bus.right  = r_pulse[1];
  assign bus.center = r_pulse[0];
  assign bus.held   = r_stable;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int DEB_T  = 4;
  localparam int DLY_T  = 10;
  localparam int RATE_T = 5;
  localparam int LAT    = DEB_T + 3;   // raw edge -> pulse cycle
  localparam int GAP    = 16;

  localparam logic [4:0] B_UP = 5'b10000, B_DN = 5'b01000, B_LF = 5'b00100,
                         B_RT = 5'b00010, B_CT = 5'b00001;

  typedef struct {
    string      name;
    logic [4:0] raw;
    logic       adj;
    int         hold;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  exp_t exp_q[$];

  button_conditioner_if bif ();

  button_conditioner #(
    .DEB_CYCLES  (DEB_T),
    .REPEAT_DELAY(DLY_T),
    .REPEAT_RATE (RATE_T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bif.up, bif.down, bif.left, bif.right, bif.center};
  endfunction

  task automatic set_raw(input logic [4:0] r);
    {bif.up_raw, bif.down_raw, bif.left_raw, bif.right_raw, bif.center_raw} = r;
  endtask

  task automatic push(input int c, input logic [4:0] m);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every cycle the pulse outputs must equal the expectations
  // scheduled for that cycle (zero when nothing is scheduled).
  always @(negedge clk) begin
    if (mon_en) begin
      logic [4:0] e;
      e = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        if (exp_q[0].cyc == cyc) e |= exp_q[0].mask;
        else chk("late_pulse", 5'b00000, exp_q[0].mask);
        void'(exp_q.pop_front());
      end
      chk("pulses", outs(), e);
    end
  end

  task automatic run_vec(input vec_t v);
    int         c0;
    logic       acc;
    logic [4:0] ud;
    int         t;
    c0  = cyc;
    acc = (v.hold >= DEB_T);
    ud  = v.raw & (B_UP | B_DN);
    if (acc) begin
      push(c0 + LAT, v.raw);
      if (v.adj && (ud == B_UP || ud == B_DN)) begin
        t = LAT + DLY_T;
        while (t < v.hold + DEB_T + 2) begin
          push(c0 + t, ud);
          t += RATE_T;
        end
      end
    end
    bif.adjust = v.adj;
    set_raw(v.raw);
    for (int k = 0; k < v.hold + GAP; k++) begin
      if (k == v.hold) set_raw('0);
      @(negedge clk);
      if (k == DEB_T + 1) chk({v.name, "_held_pre"}, bif.held, 5'b00000);
      if (k == DEB_T + 2) chk({v.name, "_held"}, bif.held, acc ? v.raw : 5'b00000);
      step();
    end
    bif.adjust = 1'b0;
  endtask

  initial begin
    vec_t vecs[10];
    int   c0;
    int   p;

    vecs[0] = '{"right_adj0",   B_RT,               1'b0, 30};
    vecs[1] = '{"center_glitch", B_CT,              1'b0, 3};
    vecs[2] = '{"center_min",   B_CT,               1'b0, DEB_T};
    vecs[3] = '{"up_repeat",    B_UP,               1'b1, 38};
    vecs[4] = '{"down_repeat",  B_DN,               1'b1, 25};
    vecs[5] = '{"up_down_both", B_UP | B_DN,        1'b1, 38};
    vecs[6] = '{"left_adj1",    B_LF,               1'b1, 30};
    vecs[7] = '{"up_adj0",      B_UP,               1'b0, 30};
    vecs[8] = '{"lrc_together", B_LF | B_RT | B_CT, 1'b1, 20};
    vecs[9] = '{"down_glitch",  B_DN,               1'b1, DEB_T - 1};

    set_raw('0);
    bif.adjust = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_pulses", outs(), 5'b00000);
    chk("reset_held", bif.held, 5'b00000);
    step();
    rst = 1'b1;
    repeat (4) step();
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Bouncing left: 2 cycles high / 2 low for 12 cycles, then steady high.
    c0 = cyc;
    push(c0 + 12 + LAT, B_LF);
    for (int k = 0; k < 12 + 15 + GAP; k++) begin
      if (k < 12) set_raw(((k / 2) % 2 == 0) ? B_LF : 5'b00000);
      else if (k < 27) set_raw(B_LF);
      else set_raw('0);
      step();
    end

    // Up held in adjust; adjust dropped at P+17, restored at P+25.
    c0 = cyc;
    p  = c0 + LAT;
    push(p, B_UP);
    push(p + DLY_T, B_UP);
    push(p + DLY_T + RATE_T, B_UP);
    push(p + 25 + 1 + DLY_T, B_UP);
    bif.adjust = 1'b1;
    set_raw(B_UP);
    for (int k = 0; k < 40 + GAP; k++) begin
      if (k == LAT + 17) bif.adjust = 1'b0;
      if (k == LAT + 25) bif.adjust = 1'b1;
      if (k == 40) set_raw('0);
      step();
    end
    bif.adjust = 1'b0;

    // Down held across a 3-cycle reset pulse: counts as a fresh press.
    c0 = cyc;
    push(c0 + LAT, B_DN);
    set_raw(B_DN);
    repeat (12) step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_held", bif.held, 5'b00000);
      chk("rst_outs", outs(), 5'b00000);
      step();
    end
    rst = 1'b1;
    push(cyc + LAT, B_DN);
    repeat (15) step();
    @(negedge clk);
    chk("post_rst_held", bif.held, B_DN);
    step();
    set_raw('0);
    repeat (GAP) step();

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses remaining=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
